// File: rtl/muxn_pipe.sv
// muxn_pipe: NCH-to-1 channel select with optional output complement, behind
// a valid/ready handshake. One output register plus one skid entry, so
// in_ready comes straight from a flop.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  upstream handshake (in_ready registered)
//   sel                 channel select, sampled on accept
//   inv                 per-beat polarity flip, XORed with INVERT
//   din                 NCH channels, channel k at din[k*WIDTH +: WIDTH]
//   out_valid, out_ready downstream handshake
//   dout                selected, possibly complemented, data
//   xfer_cnt            wrapping count of completed output handshakes
module muxn_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCH    = 4,
  parameter int unsigned INVERT = 1,
  parameter int unsigned CNTW   = 16,
  localparam int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 inv,
  input  logic [NCH*WIDTH-1:0] din,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic [CNTW-1:0]      xfer_cnt
);

  localparam logic INV_DEF = (INVERT != 0);

  // Occupancy of output register and skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  skid_q, skid_d;
  logic [CNTW-1:0]   xfer_cnt_q, xfer_cnt_d;

  logic              accept;
  logic              emit;
  logic [WIDTH-1:0]  beat;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // Beat value: selected channel, complemented when INVERT ^ inv.
  always_comb begin
    beat = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (sel == SELW'(k)) beat = din[k*WIDTH +: WIDTH];
    end
    beat = beat ^ {WIDTH{INV_DEF ^ inv}};
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      skid_q      <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      skid_q      <= skid_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  // Next occupancy state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !emit)      state_d = ST_FULL;
        else if (!accept && emit) state_d = ST_EMPTY;
      end
      ST_FULL:  if (emit) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Datapath and next values of the registered outputs.
  always_comb begin
    dout_d      = dout_q;
    skid_d      = skid_q;
    xfer_cnt_d  = xfer_cnt_q;
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    if (emit) xfer_cnt_d = xfer_cnt_q + CNTW'(1);
    unique case (state_q)
      ST_EMPTY: if (accept) dout_d = beat;
      ST_ONE: begin
        if (accept) begin
          // Emitting frees dout for the new beat; otherwise park it in skid.
          if (emit) dout_d = beat;
          else      skid_d = beat;
        end
      end
      ST_FULL:  if (emit) dout_d = skid_q;
      default:  ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
